sisc_fetch_unit: RTL and testbench

//  Instruction-fetch responder driven by the SISC control FSM's ir_load/pc_write/pc_sel/br_sel/pc_rst strobes.

---
 rtl/sisc_fetch_unit_if.sv | 21 ++
 rtl/sisc_fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_sisc_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory fetch bus: req/rdy request channel plus rvalid read-return channel.
interface sisc_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rdy;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdy, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdy, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, prefetch FIFO and IR behind the ctrl strobes.
// Define FETCH_PERF_EN to add the stall_cnt / flush_cnt performance counters.
//
// state  | meaning
// S_IDLE | no request in flight; issue when FIFO has room
// S_REQ  | mem_req high, waiting for mem_rdy
// S_WAIT | request accepted, waiting for mem_rvalid (drop_q = discard it)
module sisc_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  sisc_fetch_unit_if.master  mem,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [ADDR_W-1:0]  pc,
  output logic               ir_valid,
  output logic               stall
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  wait_addr_q, wait_addr_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               stall_q, stall_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
  logic [INSTR_W-1:0] fifo_data_q [DEPTH];

  logic               clr, redirect, rsp, push, empty, load_req, pop, bypass, fifo_wr;
  logic [ADDR_W-1:0]  imm, target;

  assign clr      = rst_f | pc_rst;
  assign redirect = pc_write & pc_sel;
  assign imm      = ADDR_W'(ir_q[15:0]);
  assign target   = br_sel ? imm : pc_q + imm;

  assign rsp      = (state_q == S_WAIT) & mem.mem_rvalid;
  assign push     = rsp & ~drop_q & ~redirect;
  assign empty    = (count_q == '0);
  // a pending stall keeps asking for an instruction until one arrives
  assign load_req = (ir_load | stall_q) & ~redirect;
  assign pop      = load_req & ~empty;
  assign bypass   = load_req & empty & push;
  assign fifo_wr  = push & ~bypass;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    wait_addr_d = wait_addr_q;
    drop_d      = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect)                         fetch_pc_d = target;
        else if (count_q < (PTR_W+1)'(DEPTH)) state_d    = S_REQ;
      end
      S_REQ: begin
        if (mem.mem_rdy) begin
          wait_addr_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
          state_d     = S_WAIT;
        end
        if (redirect) begin
          fetch_pc_d = target;
          if (mem.mem_rdy) drop_d  = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
        if (redirect) begin
          fetch_pc_d = target;
          if (!mem.mem_rvalid) drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_wr && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (!fifo_wr && pop) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    ir_d       = ir_q;
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    stall_d    = load_req & empty & ~push;
    if (pop) begin
      ir_d       = fifo_data_q[rd_ptr_q];
      pc_d       = fifo_addr_q[rd_ptr_q] + ADDR_W'(1);
      ir_valid_d = 1'b1;
    end else if (bypass) begin
      ir_d       = mem.mem_rdata;
      pc_d       = wait_addr_q + ADDR_W'(1);
      ir_valid_d = 1'b1;
    end else if (redirect) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= '0;
      wait_addr_q <= '0;
      drop_q      <= 1'b0;
      ir_q        <= '0;
      pc_q        <= '0;
      ir_valid_q  <= 1'b0;
      stall_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      wait_addr_q <= wait_addr_d;
      drop_q      <= drop_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      ir_valid_q  <= ir_valid_d;
      stall_q     <= stall_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && fifo_wr) begin
      fifo_addr_q[wr_ptr_q] <= wait_addr_q;
      fifo_data_q[wr_ptr_q] <= mem.mem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_q && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign mem.mem_req  = (state_q == S_REQ);
  assign mem.mem_addr = fetch_pc_q;
  assign ir           = ir_q;
  assign opcode       = ir_q[INSTR_W-1 -: 4];
  assign mm           = ir_q[INSTR_W-5 -: 4];
  assign pc           = pc_q;
  assign ir_valid     = ir_valid_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: behavioural instruction memory with programmable latency and an IR scoreboard.
module tb_sisc_fetch_unit;

  logic clk = 1'b0;
  logic rst_f = 1'b1, pc_rst = 1'b0, ir_load = 1'b0;
  logic pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] pc;
  logic        ir_valid, stall;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  sisc_fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) mif ();

  sisc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .pc_rst   (pc_rst),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .mem      (mif),
    .ir       (ir),
    .opcode   (opcode),
    .mm       (mm),
    .pc       (pc),
    .ir_valid (ir_valid),
    .stall    (stall)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] acc_q[$];
  int          n_cmp = 0, n_err = 0;
  int          n_overlap = 0, n_redir = 0;
  int          lat = 1, pcnt = 0;
  bit          pend = 1'b0;
  logic [15:0] paddr = '0;

  // address 4 carries imm = FFFE so the redirect targets are easy to predict
  function automatic logic [31:0] instr_at(input logic [15:0] a);
    if (a == 16'd4) return {4'h3, 4'h1, 8'h00, 16'hFFFE};
    return {4'hA, a[3:0], 8'h5A, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with ctrl inputs final; plays the memory for the coming edge.
  task automatic tick();
    mif.mem_rvalid = 1'b0;
    if (pend) begin
      if (pcnt == 1) begin
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = instr_at(paddr);
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (mif.mem_req && mif.mem_rdy) begin
      if (pend) n_overlap++;
      acc_q.push_back(mif.mem_addr);
      pend  = 1'b1;
      pcnt  = lat;
      paddr = mif.mem_addr;
    end
    @(negedge clk);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    int   n = 0;
    while (stall && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(stall), 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_ir"}, 64'(ir), 64'(e.instr));
    check({tag, "_pc"}, 64'(pc), 64'(e.pc));
    check({tag, "_valid"}, 64'(ir_valid), 64'd1);
    check({tag, "_opcode"}, 64'(opcode), 64'(e.instr[31:28]));
    check({tag, "_mm"}, 64'(mm), 64'(e.instr[27:24]));
  endtask

  task automatic do_load(input string tag, input logic [15:0] a);
    exp_t e;
    e.instr = instr_at(a);
    e.pc    = a + 16'd1;
    sb_q.push_back(e);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    compare_head(tag);
  endtask

  task automatic redirect(input logic bsel, input logic also_load);
    pc_write = 1'b1;
    pc_sel   = 1'b1;
    br_sel   = bsel;
    ir_load  = also_load;
    tick();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    n_redir++;
    acc_q.delete();
  endtask

  task automatic wait_acc(input string tag, input logic [15:0] a);
    int n = 0;
    while (acc_q.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    if (acc_q.size() == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    else                   check(tag, 64'(acc_q[0]), 64'(a));
  endtask

  task automatic wait_pend(input bit level);
    int n = 0;
    while (pend != level && n < 60) begin
      tick();
      n++;
    end
    check("wait_pend", 64'(pend), 64'(level));
  endtask

  initial begin
    logic [31:0] ir_before;
    int sc, n;
    mif.mem_rdy    = 1'b1;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    @(negedge clk);
    repeat (3) tick();
    check("rst_mem_req", 64'(mif.mem_req), 64'd0);
    check("rst_mem_addr", 64'(mif.mem_addr), 64'd0);
    check("rst_ir", 64'(ir), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_ir_valid", 64'(ir_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // prefetch fills exactly DEPTH entries, then stops requesting
    rst_f = 1'b0;
    acc_q.delete();
    repeat (15) tick();
    check("fill_req_count", 64'(acc_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      check("fill_req_addr", 64'(acc_q[i]), 64'(i));
    check("fill_req_idle", 64'(mif.mem_req), 64'd0);

    for (int i = 0; i < 5; i++) do_load("seq_load", 16'(i));

    // relative redirect: 5 + FFFE wraps to 3
    redirect(1'b0, 1'b0);
    check("redir_rel_invalid", 64'(ir_valid), 64'd0);
    wait_acc("redir_rel_addr", 16'd3);
    do_load("rel_load3", 16'd3);
    do_load("rel_load4", 16'd4);

    // absolute redirect to FFFE, then fetch_pc/pc wrap through FFFF -> 0
    redirect(1'b1, 1'b0);
    wait_acc("redir_abs_addr", 16'hFFFE);
    do_load("abs_loadFFFE", 16'hFFFE);
    do_load("wrap_loadFFFF", 16'hFFFF);
    do_load("wrap_load0", 16'd0);

    // redirect together with ir_load: redirect wins, IR holds
    mif.mem_rdy = 1'b0;
    wait_pend(1'b0);
    repeat (2) tick();
    lat = 5;
    ir_before = ir;
    redirect(1'b1, 1'b1);
    check("both_ir_hold", 64'(ir), 64'(ir_before));
    check("both_invalid", 64'(ir_valid), 64'd0);
    check("both_no_stall", 64'(stall), 64'd0);

    // ir_load on empty FIFO at the accept edge, 5-cycle latency
    mif.mem_rdy = 1'b1;
    n = 0;
    while (!mif.mem_req && n < 20) begin
      tick();
      n++;
    end
    check("stall_req_seen", 64'(mif.mem_req), 64'd1);
    sb_q.push_back('{instr: instr_at(16'd0), pc: 16'd1});
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    sc = 0;
    n  = 0;
    while (stall && n < 30) begin
      sc++;
      tick();
      n++;
    end
    check("stall_cycles", 64'(sc), 64'd5);
    compare_head("stall_bypass");

    // redirect while a response is outstanding: stale data must not appear
    wait_pend(1'b1);
    redirect(1'b1, 1'b0);
    do_load("drop_load0", 16'd0);

    // pc_rst mid-WAIT: response discarded, refetch from 0
    wait_pend(1'b1);
    mif.mem_rdy = 1'b0;
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    check("pcrst_pc", 64'(pc), 64'd0);
    check("pcrst_ir", 64'(ir), 64'd0);
    check("pcrst_valid", 64'(ir_valid), 64'd0);
    check("pcrst_stall", 64'(stall), 64'd0);
    wait_pend(1'b0);
    repeat (2) tick();
    acc_q.delete();
    lat = 1;
    mif.mem_rdy = 1'b1;
    wait_acc("pcrst_refetch", 16'd0);
    do_load("pcrst_load0", 16'd0);
    do_load("pcrst_load1", 16'd1);

    check("overlap_requests", 64'(n_overlap), 64'd0);
`ifdef FETCH_PERF_EN
    check("flush_cnt", 64'(flush_cnt), 64'd0);
    // pc_rst above cleared the counters; three fresh redirects
    for (int i = 0; i < 3; i++) redirect(1'b1, 1'b0);
    check("flush_cnt_3", 64'(flush_cnt), 64'd3);
`endif
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
